// File: rtl/nanov_store_io.sv
// nanov_store_io
//   Write-only memory-mapped I/O stage that sits directly after the nanoV CPU
//   store port. Each store has two parts: an address strobe and then a data
//   strobe. Stores to SPI memory space (address[31:24] == 0) are discarded.
//   Peripheral stores are decoded on address[3:2]:
//     0x0 : gpio_out <= V[7:0]
//     0x4 : push V[7:0] to the UART transmitter
//     0x8 : clear uart_overflow
//     0xC : ignored
//   V is the bit-reversed CPU data bus: V[i] = cpu_data[31-i].
//
//   Optional feature macro: NANOV_UART_FIFO_EN
//     defined   : FIFO_DEPTH-entry circular FIFO in front of the UART FSM
//     undefined : single holding register in front of the UART FSM
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (4..4095)
//   FIFO_DEPTH   : TX FIFO entries, power of two 2..16 (FIFO build only)
//
// Ports
//   clk           in   clock
//   rstn          in   synchronous active-low reset
//   cpu_data      in   CPU data_out bus (address or bit-reversed data)
//   store_addr    in   cpu_data holds a store address this cycle
//   store_data    in   cpu_data holds store data this cycle
//   gpio_out      out  8-bit GPIO output register
//   uart_tx       out  8N1 serial output, idle high
//   uart_busy     out  transmitter active or TX data pending
//   uart_overflow out  sticky flag: a UART write was dropped
//
// Handshake: there is no back-pressure. A strobe is consumed on the clock
// edge where it is high; the CPU guarantees stores are widely spaced.

module nanov_store_io #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cpu_data,
  input  logic        store_addr,
  input  logic        store_data,
  output logic [7:0]  gpio_out,
  output logic        uart_tx,
  output logic        uart_busy,
  output logic        uart_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------
  // Address latch and decode
  // ---------------------------------------------------------------------
  // Only address bits [31:24] and [3:2] take part in decoding, so only
  // those are held: {region[7:0], reg_sel[1:0]}.
  logic [9:0] addr_q, addr_d;
  logic       pending_q, pending_d;
  logic [7:0] gpio_q, gpio_d;
  logic       ovf_q, ovf_d;
  logic [7:0] store_v;

  logic       act;
  logic       gpio_we;
  logic       push_req;
  logic       clr_ovf;
  logic       push_ok;
  logic       push_drop;

  // Bits of the bus that never influence behaviour.
  logic unused_bus;
  assign unused_bus = ^{cpu_data[23:4], cpu_data[1:0]};

  always_comb begin
    store_v = '0;
    for (int i = 0; i < 8; i++) begin
      store_v[i] = cpu_data[31-i];
    end
  end

  // The data strobe always uses the previously latched address, so a
  // simultaneous address strobe only affects the next store.
  assign act       = store_data && pending_q && (addr_q[9:2] != 8'h00);
  assign gpio_we   = act && (addr_q[1:0] == 2'd0);
  assign push_req  = act && (addr_q[1:0] == 2'd1);
  assign clr_ovf   = act && (addr_q[1:0] == 2'd2);
  assign push_drop = push_req && !push_ok;

  always_comb begin
    addr_d    = addr_q;
    pending_d = pending_q;
    gpio_d    = gpio_q;
    ovf_d     = ovf_q;
    if (store_data && pending_q) begin
      pending_d = 1'b0;
    end
    if (store_addr) begin
      addr_d    = {cpu_data[31:24], cpu_data[3:2]};
      pending_d = 1'b1;
    end
    if (gpio_we) begin
      gpio_d = store_v;
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (push_drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      pending_q <= 1'b0;
      gpio_q    <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pending_q <= pending_d;
      gpio_q    <= gpio_d;
      ovf_q     <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------
  // TX buffer between the decoder and the UART FSM
  // ---------------------------------------------------------------------
  logic       tx_avail;
  logic [7:0] tx_byte;
  logic       pop;

`ifdef NANOV_UART_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          push_acc;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok  = !full || pop;
  assign push_acc = push_req && push_ok;
  assign tx_avail = (count_q != '0);
  assign tx_byte  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_acc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= store_v;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  // The holding register is freed when the FSM loads it at START entry.
  assign push_ok  = !hold_valid_q || pop;
  assign tx_avail = hold_valid_q;
  assign tx_byte  = hold_q;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (pop) begin
      hold_valid_d = 1'b0;
    end
    if (push_req && push_ok) begin
      hold_d       = store_v;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // UART 8N1 transmitter FSM
  // ---------------------------------------------------------------------
  uart_state_e state_q;
  logic [11:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_done;

  assign bit_done = (cnt_q == BIT_LAST);

  // The buffer is read exactly when a start bit begins: from IDLE, or
  // straight out of the last stop-bit cycle for gap-free back-to-back bytes.
  assign pop = tx_avail &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (tx_avail) begin
            state_q <= ST_START;
            shift_q <= tx_byte;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (tx_avail) begin
              state_q <= ST_START;
              shift_q <= tx_byte;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign gpio_out      = gpio_q;
  assign uart_tx       = tx_q;
  assign uart_busy     = (state_q != ST_IDLE) || tx_avail;
  assign uart_overflow = ovf_q;

endmodule

// File: tb/tb_nanov_store_io.sv
// Directed testbench for nanov_store_io with CLKS_PER_BIT = 8.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_nanov_store_io;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
`ifdef NANOV_UART_FIFO_EN
  localparam int N_OK  = DEPTH + 1;   // FIFO entries plus the shift register
`else
  localparam int N_OK  = 2;           // holding register plus the shift register
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cpu_data;
  logic        store_addr;
  logic        store_data;
  logic [7:0]  gpio_out;
  logic        uart_tx;
  logic        uart_busy;
  logic        uart_overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nanov_store_io #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cpu_data     (cpu_data),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .gpio_out     (gpio_out),
    .uart_tx      (uart_tx),
    .uart_busy    (uart_busy),
    .uart_overflow(uart_overflow)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // CPU sends data bit-reversed: cpu_data[31-i] carries bit i.
  function automatic logic [31:0] enc(input logic [7:0] v);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[31-i] = v[i];
    return d;
  endfunction

  task automatic send_addr(input logic [31:0] a);
    cpu_data   = a;
    store_addr = 1'b1;
    tick();
    store_addr = 1'b0;
    cpu_data   = '0;
  endtask

  task automatic send_data(input logic [7:0] v);
    cpu_data   = enc(v);
    store_data = 1'b1;
    tick();
    store_data = 1'b0;
    cpu_data   = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [7:0] v);
    send_addr(a);
    send_data(v);
  endtask

  logic [9:0] frame_55;
  int e1;

  initial begin
    rstn = 1'b0; cpu_data = '0; store_addr = 1'b0; store_data = 1'b0;
    frame_55 = 10'b1_01010101_0;   // {stop, data MSB..LSB, start}
    tick(); tick(); tick();
    rstn = 1'b1;
    tick();
    check("rst_gpio", gpio_out, 8'h00);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", uart_busy, 1'b0);
    check("rst_ovf", uart_overflow, 1'b0);

    // GPIO write, visible right after the data edge
    cpu_data = 32'h1000_0000; store_addr = 1'b1; tick(); store_addr = 1'b0;
    cpu_data = 32'hA500_0000; store_data = 1'b1; tick(); store_data = 1'b0;
    check("gpio_a5", gpio_out, 8'hA5);
    check("gpio_a5_tx", uart_tx, 1'b1);
    check("gpio_a5_busy", uart_busy, 1'b0);

    // memory-space store is ignored and consumes the pending address
    do_store(32'h0000_0100, 8'h5A);
    check("mem_gpio", gpio_out, 8'hA5);
    check("mem_busy", uart_busy, 1'b0);
    send_data(8'h11);
    check("orphan_data_gpio", gpio_out, 8'hA5);
    check("orphan_data_busy", uart_busy, 1'b0);

    // second address overwrites the first
    send_addr(32'h1000_0004);
    send_addr(32'h1000_0000);
    send_data(8'h3C);
    check("readdr_gpio", gpio_out, 8'h3C);
    check("readdr_busy", uart_busy, 1'b0);

    // register 0xC is ignored
    do_store(32'h1000_000C, 8'hFF);
    check("regc_gpio", gpio_out, 8'h3C);
    check("regc_busy", uart_busy, 1'b0);

    // single frame 0x55
    do_store(32'h1000_0004, 8'h55);
    check("push_busy", uart_busy, 1'b1);
    check("push_tx_idle", uart_tx, 1'b1);
    tick();
    for (int j = 0; j < FRAME; j++) begin
      check($sformatf("frame55_tx_%0d", j), uart_tx, frame_55[j / CPB]);
      check($sformatf("frame55_busy_%0d", j), uart_busy, 1'b1);
      tick();
    end
    check("frame55_end_busy", uart_busy, 1'b0);
    check("frame55_end_tx", uart_tx, 1'b1);
    check("frame55_gpio", gpio_out, 8'h3C);

    // burst: N_OK bytes accepted, one more dropped
    do_store(32'h1000_0004, 8'h01);
    e1 = cyc;
    for (int k = 2; k <= N_OK; k++) do_store(32'h1000_0004, 8'(k));
    check("burst_ovf_clear", uart_overflow, 1'b0);
    do_store(32'h1000_0004, 8'(N_OK + 1));
    check("burst_ovf_set", uart_overflow, 1'b1);
    for (int k = 1; k < N_OK; k++) begin
      wait_until(e1 + FRAME * k);
      check($sformatf("b2b_stop_%0d", k), uart_tx, 1'b1);
      tick();
      check($sformatf("b2b_start_%0d", k), uart_tx, 1'b0);
      if (k == 1) begin
        // byte 0x02: bit0 = 0, bit1 = 1 (sampled mid-bit)
        wait_until(e1 + 1 + FRAME + CPB + CPB / 2);
        check("byte2_bit0", uart_tx, 1'b0);
        wait_until(e1 + 1 + FRAME + 2 * CPB + CPB / 2);
        check("byte2_bit1", uart_tx, 1'b1);
      end
    end
    wait_until(e1 + FRAME * N_OK);
    check("burst_last_busy", uart_busy, 1'b1);
    tick();
    check("burst_done_busy", uart_busy, 1'b0);
    check("burst_done_tx", uart_tx, 1'b1);
    check("burst_ovf_sticky", uart_overflow, 1'b1);

    // clear overflow
    do_store(32'h1000_0008, 8'h00);
    check("ovf_cleared", uart_overflow, 1'b0);
    check("ovf_clr_busy", uart_busy, 1'b0);

    // reset in the middle of data bit 3 of 0x00, with the buffer full
    do_store(32'h1000_0004, 8'h00);
    e1 = cyc;
    for (int k = 0; k < N_OK; k++) do_store(32'h1000_0004, 8'hFF);
    check("pre_rst_ovf", uart_overflow, 1'b1);
    wait_until(e1 + 1 + 4 * CPB + 3);
    check("pre_rst_tx_bit3", uart_tx, 1'b0);
    check("pre_rst_busy", uart_busy, 1'b1);
    rstn = 1'b0;
    tick();
    check("midrst_tx", uart_tx, 1'b1);
    check("midrst_busy", uart_busy, 1'b0);
    check("midrst_gpio", gpio_out, 8'h00);
    check("midrst_ovf", uart_overflow, 1'b0);
    rstn = 1'b1;
    tick(); tick(); tick();
    check("post_rst_busy", uart_busy, 1'b0);
    check("post_rst_tx", uart_tx, 1'b1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
